mux_arbiter_4: RTL and testbench

MUX_ARBITER_4 -- requirements
Module: mux_arbiter_4

---
 rtl/mux_arbiter_4.sv | 112 +++++++++++
 tb/tb_mux_arbiter_4.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_4.sv
// Four-requester round-robin arbiter driving a shared 4:1 data mux.
// Optional grant-tenure limit enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_arbiter_4 #(
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] data_in,
  output logic [3:0]     grant,
  output logic [1:0]     sel,
  output logic [W-1:0]   data_out,
  output logic           valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] others;
  logic [1:0] start;
  logic [1:0] nxt;
  logic       hit;
  logic       handoff;

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("mux_arbiter_4: MAX_HOLD must be at least 1");
  end

  // Returns {found, index} of the first set bit scanning from 'from' upward, mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] from);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = from + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned     CW   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0]   CMAX = CW'(MAX_HOLD - 1);
  logic [CW-1:0] cnt;
`endif

  // grant is zero in IDLE, so others==req there and one search serves both states.
  always_comb begin
    others     = req & ~grant;
    start      = (state == IDLE) ? ptr : sel + 2'd1;
    {hit, nxt} = pick(others, start);
    handoff    = !req[sel];
`ifdef MUX_ARB_TIMEOUT_EN
    handoff    = handoff || ((cnt == CMAX) && (|others));
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      grant <= '0;
      valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state <= GRANT;
            grant <= 4'b0001 << nxt;
            sel   <= nxt;
            valid <= 1'b1;
          end
        end
        GRANT: begin
          if (handoff) begin
            ptr <= sel + 2'd1;
            if (hit) begin
              grant <= 4'b0001 << nxt;
              sel   <= nxt;
            end else begin
              state <= IDLE;
              grant <= '0;
              valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == IDLE || handoff) begin
      cnt <= '0;
    end else if (cnt != CMAX) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    data_out = '0;
    if (valid) data_out = data_in[sel*W +: W];
  end

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Randomized scoreboard bench for mux_arbiter_4 against an integer-level arbitration model.
module tb_mux_arbiter_4;

  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req;
  logic [4*W-1:0] data_in;
  logic [3:0]     grant;
  logic [1:0]     sel;
  logic [W-1:0]   data_out;
  logic           valid;

  mux_arbiter_4 #(.W(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant), .sel(sel), .data_out(data_out), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic [7:0] d;
    string      tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit done   = 0;

  // Model state: owner is -1 when nobody holds the bus.
  int m_owner  = -1;
  int m_ptr    = 0;
  int m_last   = 0;
  int m_tenure = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int from);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (from + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] slice(input logic [31:0] d, input int i);
    return d[i*8 +: 8];
  endfunction

  // One clock of the reference: apply the rules to the sampled request vector.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    bit rel;
    if (m_owner < 0) begin
      m_owner = first_from(r, m_ptr);
      if (m_owner >= 0) begin
        m_last   = m_owner;
        m_tenure = 0;
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      rel = !r[m_owner];
`ifdef MUX_ARB_TIMEOUT_EN
      if (m_tenure == MH - 1 && oth != 4'b0) rel = 1;
`endif
      if (rel) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = first_from(oth, m_ptr);
        if (m_owner >= 0) m_last = m_owner;
        m_tenure = 0;
      end else if (m_tenure < MH - 1) begin
        m_tenure++;
      end
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic [31:0] d, input string tag);
    exp_t e;
    @(negedge clk);
    req     = r;
    data_in = d;
    model_step(r);
    e.g   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.s   = 2'(m_last);
    e.v   = (m_owner >= 0);
    e.d   = (m_owner >= 0) ? slice(d, m_owner) : 8'h00;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: one registered result per clock, compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, "_grant"}, 32'(grant), 32'(e.g));
        chk({e.tag, "_sel"},   32'(sel),   32'(e.s));
        chk({e.tag, "_valid"}, 32'(valid), 32'(e.v));
        chk({e.tag, "_data"},  32'(data_out), 32'(e.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  localparam logic [31:0] DPAT = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

  initial begin
    logic [3:0]  r;
    logic [31:0] d;
    reset   = 1'b1;
    req     = 4'b1111;
    data_in = DPAT;
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sel",   32'(sel),   0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data",  32'(data_out), 0);
    @(negedge clk);
    reset = 1'b0;

    repeat (3) cycle(4'b1111, DPAT, "hold0");
    cycle(4'b1110, DPAT, "pass1");
    cycle(4'b1100, DPAT, "pass2");
    cycle(4'b1000, DPAT, "pass3");
    cycle(4'b0000, DPAT, "idle_sel3");
    cycle(4'b0000, DPAT, "idle2");
    cycle(4'b1000, DPAT, "own3");
    cycle(4'b0011, DPAT, "wrap");
    cycle(4'b0000, DPAT, "idle3");
    cycle(4'b0100, DPAT, "own2");
    cycle(4'b0100, DPAT, "own2b");

    // Asynchronous reset between edges while requester 2 owns the bus.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 0);
    chk("async_valid", 32'(valid), 0);
    chk("async_data",  32'(data_out), 0);
    chk("async_sel",   32'(sel), 0);
    @(negedge clk);
    reset    = 1'b0;
    m_owner  = -1;
    m_ptr    = 0;
    m_last   = 0;
    m_tenure = 0;
    cycle(4'b0100, DPAT, "post_rst");
    cycle(4'b0000, DPAT, "post_idle");
    cycle(4'b1010, DPAT, "from0");
    cycle(4'b0000, DPAT, "idle4");

    repeat (12) cycle(4'b0011, DPAT, "tenure");
    cycle(4'b0000, DPAT, "idle5");

    r = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] = 1'b0;
      d = $urandom;
      cycle(r, d, "rand");
    end
    cycle(4'b0000, DPAT, "drain");

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
